// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// word size and the default reset PC.
package fetch_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with sequential increment and wrap at the top of the rom.
// With FETCH_REDIRECT_EN defined, a redirect loads a word-aligned target instead.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
`ifdef FETCH_REDIRECT_EN
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`endif
  output logic [31:0] pc
);

  localparam logic [31:0] LAST_PC = 32'(ROM_WORDS * WORD_BYTES - WORD_BYTES);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // A redirect overrides the sequential advance; the target's low bits are dropped.
  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      pc_d = (pc_q == LAST_PC) ? 32'h0 : pc_q + 32'(WORD_BYTES);
    end
`ifdef FETCH_REDIRECT_EN
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one rom read per word and holds it until accepted.
// Defining FETCH_REDIRECT_EN adds the redirect_valid/redirect_pc ports.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`endif
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic [31:0]  pc;
  logic         capture;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .ROM_WORDS(ROM_WORDS)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .advance       (capture),
`ifdef FETCH_REDIRECT_EN
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
`endif
    .pc            (pc)
  );

  // A redirect wins over everything and also suppresses the capture of an in-flight read.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:    if (run) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD:    if (instr_ready) state_d = run ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FETCH_REDIRECT_EN
    if (redirect_valid) begin
      state_d = ISSUE;
      capture = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        instr_q    <= rom_data;
        instr_pc_q <= pc;
      end
    end
  end

  assign rom_addr    = pc;
  assign rom_en      = (state_q == ISSUE);
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule
